// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg
//   Shared constants and types for the video RAM arbiter.
//   MEMORY_SIZE_BITS / COLOR_SIZE : video RAM address and pixel widths.
//   VRAM_DEPTH                    : number of valid RAM entries (1122).
//   grant_e                       : last-grant debug encoding.
//   rd_tag_t                      : per-stage tag of the read-return pipeline.
package vram_arbiter_pkg;

    localparam int MEMORY_SIZE_BITS = 11;
    localparam int COLOR_SIZE       = 3;
    localparam int VRAM_DEPTH       = 1122;

    typedef enum logic [1:0] {
        GRANT_IDLE = 2'b00,
        GRANT_RD   = 2'b01,
        GRANT_WR   = 2'b10
    } grant_e;

    typedef struct packed {
        logic vld;   // a read was granted at this stage's entry edge
        logic inr;   // that read address was inside the RAM
    } rd_tag_t;

endpackage

// File: rtl/vram_rd_pipe.sv
// vram_rd_pipe
//   READ_LATENCY-deep shift register carrying {granted, in_range} for each
//   read so the tag lines up with the RAM q output.
//   clk_i  : clock
//   rst_ni : asynchronous active-low clear (drops in-flight reads)
//   tag_i  : tag of the read granted this cycle
//   tag_o  : tag of the read whose data is on q this cycle
module vram_rd_pipe
    import vram_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t [READ_LATENCY-1:0] pipe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Owns the single port of the video RAM and shares it between the painter
//   (writer) and the screen flasher (reader). Reads win by default to protect
//   display timing; a streak counter hands the port to a waiting writer after
//   MAX_READ_STREAK consecutive reads.
//   Clck, Reset                  : clock, async active-low reset
//   wr_req/wr_addr/wr_data/wr_grant : painter write handshake
//   rd_req/rd_addr/rd_grant      : flasher read handshake
//   rd_valid/rd_data             : read return, READ_LATENCY after rd_grant
//   mem_address/mem_data/mem_wren/mem_q : RAM port
//   addr_err                     : sticky out-of-range access flag
//   last_grant                   : previous cycle's grant (00 idle/01 rd/10 wr)
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int MEM_ADDR_W      = MEMORY_SIZE_BITS,
    parameter int MEM_DEPTH       = VRAM_DEPTH,
    parameter int COLOR_W         = COLOR_SIZE,
    parameter int READ_LATENCY    = 1,
    parameter int MAX_READ_STREAK = 8
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic                  wr_req,
    input  logic [MEM_ADDR_W-1:0] wr_addr,
    input  logic [COLOR_W-1:0]    wr_data,
    output logic                  wr_grant,
    input  logic                  rd_req,
    input  logic [MEM_ADDR_W-1:0] rd_addr,
    output logic                  rd_grant,
    output logic                  rd_valid,
    output logic [COLOR_W-1:0]    rd_data,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [COLOR_W-1:0]    mem_data,
    output logic                  mem_wren,
    input  logic [COLOR_W-1:0]    mem_q,
    output logic                  addr_err,
    output logic [1:0]            last_grant
);

    localparam int                    STREAK_W   = $clog2(MAX_READ_STREAK + 1);
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_READ_STREAK);
    localparam logic [MEM_ADDR_W-1:0] DEPTH_A    = MEM_ADDR_W'(MEM_DEPTH);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                addr_err_q, addr_err_d;
    grant_e              last_grant_q, last_grant_d;
    logic                streak_full;
    logic                rd_in_range, wr_in_range;
    rd_tag_t             tag_in, tag_out;

    assign streak_full = (streak_q == STREAK_MAX);
    assign rd_in_range = (rd_addr < DEPTH_A);
    assign wr_in_range = (wr_addr < DEPTH_A);

    // Grants are gated by Reset so nothing reaches the RAM while held in reset.
    // The two terms are mutually exclusive: on contention streak_full picks one.
    assign rd_grant = Reset && rd_req && (!wr_req || !streak_full);
    assign wr_grant = Reset && wr_req && (!rd_req ||  streak_full);

    // RAM bus: idle drives zeros; out-of-range writes still get a grant but
    // never assert wren, so the requester completes and the RAM is untouched.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (rd_grant) begin
            mem_address = rd_addr;
        end else if (wr_grant) begin
            mem_address = wr_addr;
            mem_data    = wr_data;
            mem_wren    = wr_in_range;
        end
    end

    always_comb begin
        streak_d = streak_q;
        // The streak only measures reads that made a pending writer wait.
        if (!wr_req || wr_grant) begin
            streak_d = '0;
        end else if (rd_grant && !streak_full) begin
            streak_d = streak_q + STREAK_W'(1);
        end

        addr_err_d = addr_err_q
                   | (rd_grant && !rd_in_range)
                   | (wr_grant && !wr_in_range);

        last_grant_d = rd_grant ? GRANT_RD : (wr_grant ? GRANT_WR : GRANT_IDLE);
    end

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            streak_q     <= '0;
            addr_err_q   <= 1'b0;
            last_grant_q <= GRANT_IDLE;
        end else begin
            streak_q     <= streak_d;
            addr_err_q   <= addr_err_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign tag_in = rd_tag_t'{vld: rd_grant, inr: rd_in_range};

    vram_rd_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .clk_i  (Clck),
        .rst_ni (Reset),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    assign rd_valid   = tag_out.vld;
    assign rd_data    = (tag_out.vld && tag_out.inr) ? mem_q : '0;
    assign addr_err   = addr_err_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Two arbiters (READ_LATENCY 1 and 2) share one directed stimulus stream,
//   each with its own behavioural RAM. Granted reads push expected
//   {data, cycle} into a per-DUT queue; monitors pop on rd_valid.
module tb_vram_arbiter;

    localparam int AW    = 11;
    localparam int CW    = 3;
    localparam int DEPTH = 1122;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    logic Clck = 1'b0;
    always #5 Clck = ~Clck;

    logic          Reset;
    logic          wr_req, rd_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [CW-1:0] wr_data;

    logic          a_wg, a_rg, a_rv, a_wren, a_err;
    logic [CW-1:0] a_rdata, a_mdata, a_q;
    logic [AW-1:0] a_maddr;
    logic [1:0]    a_last;

    logic          b_wg, b_rg, b_rv, b_wren, b_err;
    logic [CW-1:0] b_rdata, b_mdata, b_q;
    logic [AW-1:0] b_maddr;
    logic [1:0]    b_last;

    vram_arbiter #(.READ_LATENCY(1)) dut_a (
        .Clck(Clck), .Reset(Reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(a_wg),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(a_rg),
        .rd_valid(a_rv), .rd_data(a_rdata),
        .mem_address(a_maddr), .mem_data(a_mdata), .mem_wren(a_wren), .mem_q(a_q),
        .addr_err(a_err), .last_grant(a_last)
    );

    vram_arbiter #(.READ_LATENCY(2)) dut_b (
        .Clck(Clck), .Reset(Reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(b_wg),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(b_rg),
        .rd_valid(b_rv), .rd_data(b_rdata),
        .mem_address(b_maddr), .mem_data(b_mdata), .mem_wren(b_wren), .mem_q(b_q),
        .addr_err(b_err), .last_grant(b_last)
    );

    // Behavioural single-port RAMs
    logic [CW-1:0] mem_a [DEPTH];
    logic [CW-1:0] mem_b [DEPTH];
    logic [CW-1:0] qa0, qb0, qb1;
    logic [CW-1:0] shadow [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i]  = '0;
            mem_b[i]  = '0;
            shadow[i] = '0;
        end
        qa0 = '0; qb0 = '0; qb1 = '0;
    end

    always @(posedge Clck) begin
        if (a_wren && int'(a_maddr) < DEPTH) mem_a[a_maddr] <= a_mdata;
        qa0 <= (int'(a_maddr) < DEPTH) ? mem_a[a_maddr] : '0;
        if (b_wren && int'(b_maddr) < DEPTH) mem_b[b_maddr] <= b_mdata;
        qb0 <= (int'(b_maddr) < DEPTH) ? mem_b[b_maddr] : '0;
        qb1 <= qb0;
    end
    assign a_q = qa0;
    assign b_q = qb1;

    int cyc = 0;
    always @(posedge Clck) cyc <= cyc + 1;

    int   checks   = 0;
    int   failures = 0;
    exp_t qa_exp[$];
    exp_t qb_exp[$];
    int   prev_last = 0;
    bit   err_exp   = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitors
    exp_t ea, eb;
    always @(negedge Clck) begin
        if (a_rv) begin
            if (qa_exp.size() == 0) begin
                chk("a_spurious_rd_valid", 1, 0);
            end else begin
                ea = qa_exp.pop_front();
                chk("a_rd_data", int'(a_rdata), ea.data);
                chk("a_rd_cycle", cyc, ea.cyc);
            end
        end else begin
            chk("a_rd_data_idle", int'(a_rdata), 0);
        end
    end

    always @(negedge Clck) begin
        if (b_rv) begin
            if (qb_exp.size() == 0) begin
                chk("b_spurious_rd_valid", 1, 0);
            end else begin
                eb = qb_exp.pop_front();
                chk("b_rd_data", int'(b_rdata), eb.data);
                chk("b_rd_cycle", cyc, eb.cyc);
            end
        end else begin
            chk("b_rd_data_idle", int'(b_rdata), 0);
        end
    end

    // One cycle: inputs already driven; check grants/bus mid-cycle, update model.
    task automatic step(input string nm, input bit er, input bit ew,
                        input bit ewren, input bit push);
        int exp_addr;
        int ed;
        @(negedge Clck);
        if (!Reset) begin
            prev_last = 0;
            err_exp   = 1'b0;
        end
        chk({nm, "_a_rd_grant"}, a_rg, er);
        chk({nm, "_a_wr_grant"}, a_wg, ew);
        chk({nm, "_b_rd_grant"}, b_rg, er);
        chk({nm, "_b_wr_grant"}, b_wg, ew);
        chk({nm, "_a_mem_wren"}, a_wren, ewren);
        chk({nm, "_b_mem_wren"}, b_wren, ewren);
        exp_addr = er ? int'(rd_addr) : (ew ? int'(wr_addr) : 0);
        chk({nm, "_a_mem_address"}, int'(a_maddr), exp_addr);
        if (ew && !er) chk({nm, "_a_mem_data"}, int'(a_mdata), int'(wr_data));
        chk({nm, "_a_last_grant"}, int'(a_last), prev_last);
        chk({nm, "_a_addr_err"}, a_err, err_exp);
        chk({nm, "_b_addr_err"}, b_err, err_exp);
        if (er) begin
            ed = (int'(rd_addr) < DEPTH) ? int'(shadow[rd_addr]) : 0;
            if (push) begin
                qa_exp.push_back('{ed, cyc + 1});
                qb_exp.push_back('{ed, cyc + 2});
            end
            if (int'(rd_addr) >= DEPTH) err_exp = 1'b1;
        end
        if (ew) begin
            if (int'(wr_addr) < DEPTH) shadow[wr_addr] = wr_data;
            else err_exp = 1'b1;
        end
        prev_last = er ? 1 : (ew ? 2 : 0);
        @(posedge Clck);
        #1;
    endtask

    initial begin
        Reset   = 1'b0;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_addr = 11'd5;
        wr_data = 3'b101;
        rd_addr = 11'd0;
        #1;
        // Held in reset with both requesting: nothing granted
        step("rst0", 0, 0, 0, 0);
        step("rst1", 0, 0, 0, 0);
        Reset = 1'b1;
        step("release", 1, 0, 0, 1);

        // Lone write then read-back of the same address
        rd_req = 1'b0;
        step("wr5", 0, 1, 1, 1);
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 11'd5;
        step("rd5", 1, 0, 0, 1);

        // Contention: 8 reads, 1 write, repeat
        wr_req  = 1'b1;
        wr_addr = 11'd7;
        wr_data = 3'd3;
        rd_addr = 11'd7;
        for (int i = 0; i < 20; i++) begin
            step("streak", (i % 9) != 8, (i % 9) == 8, (i % 9) == 8, 1);
        end

        // Out-of-range and last-valid addresses
        rd_req  = 1'b0;
        wr_addr = 11'd1122;
        wr_data = 3'd6;
        step("wr_oor", 0, 1, 0, 1);
        wr_addr = 11'd1121;
        wr_data = 3'd4;
        step("wr_last", 0, 1, 1, 1);
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 11'd1500;
        step("rd_oor", 1, 0, 0, 1);
        rd_addr = 11'd1121;
        step("rd_last", 1, 0, 0, 1);

        // Fill 0..9 then read them back-to-back
        rd_req = 1'b0;
        wr_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_addr = AW'(i);
            wr_data = CW'(i + 1);
            step("fill", 0, 1, 1, 1);
        end
        wr_req = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd_addr = AW'(i);
            step("b2b", 1, 0, 0, 1);
        end
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) step("gap", 0, 0, 0, 0);

        // Reset right after a read grant: its data must never appear
        rd_req  = 1'b1;
        rd_addr = 11'd3;
        step("rd_abort", 1, 0, 0, 0);
        Reset  = 1'b0;
        rd_req = 1'b0;
        step("abort_rst0", 0, 0, 0, 0);
        step("abort_rst1", 0, 0, 0, 0);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) step("post", 0, 0, 0, 0);

        chk("a_pending_reads", qa_exp.size(), 0);
        chk("b_pending_reads", qb_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
